// File: rtl/ocm_load_pkg.sv
// ==== ocm_load_pkg: shared types and helpers for the OCM table loader ====
// Rev 1.0
`default_nettype none

package ocm_load_pkg;

    localparam int MAX_CLIENTS = 32;
    localparam int CL_W        = 5;
    localparam int MAX_VEC_W   = 1024;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DRAIN     = 3'd2,
        WAIT_DONE = 3'd3,
        RUN       = 3'd4,
        ERR       = 3'd5
    } state_t;

    // Field widths handled here are at most 31 bits.
    function automatic logic [31:0] cfg_slice(input logic [MAX_VEC_W-1:0] vec,
                                              input int unsigned idx,
                                              input int unsigned width);
        logic [MAX_VEC_W-1:0] shifted;
        shifted = vec >> (idx * width);
        return shifted[31:0] & ((32'h1 << width) - 32'h1);
    endfunction

    // Lowest client index >= from with a nonzero length; MAX_CLIENTS if none.
    function automatic int next_nonzero(input logic [MAX_CLIENTS-1:0] nz, input int from);
        int   result;
        logic found;
        result = MAX_CLIENTS;
        found  = 1'b0;
        for (int i = 0; i < MAX_CLIENTS; i++) begin
            if (!found && (i >= from) && nz[i[CL_W-1:0]]) begin
                result = i;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ocm_rd_align.sv
// ==== ocm_rd_align: LAT-deep line aligning {valid, client, location} with OCM read data ====
// Rev 1.0
`default_nettype none

module ocm_rd_align #(
    parameter int LAT   = 1,
    parameter int CI_W  = 1,
    parameter int LOC_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [CI_W-1:0]  in_client,
    input  logic [LOC_W-1:0] in_loc,
    output logic             out_valid,
    output logic [CI_W-1:0]  out_client,
    output logic [LOC_W-1:0] out_loc
);

    localparam int W = 1 + CI_W + LOC_W;

    logic [W-1:0] stage [LAT];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < LAT; s++) begin
                stage[s] <= '0;
            end
        end else begin
            stage[0] <= {in_valid, in_client, in_loc};
            for (int s = 1; s < LAT; s++) begin
                stage[s] <= stage[s-1];
            end
        end
    end

    assign {out_valid, out_client, out_loc} = stage[LAT-1];

endmodule

`default_nettype wire

// File: rtl/ocm_load_sequencer.sv
// ==== ocm_load_sequencer: streams per-client OCM tables into consumers in client order ====
// Rev 1.0
`default_nettype none

module ocm_load_sequencer
    import ocm_load_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 64,
    parameter int LOC_W       = 8,
    parameter int ADDR_STEP   = 4,
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT     = 1024
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               start,
    input  logic                               en,
    input  logic [NUM_CLIENTS*ADDR_W-1:0]      cfg_base,
    input  logic [NUM_CLIENTS*(LOC_W+1)-1:0]   cfg_len,
    output logic [ADDR_W-1:0]                  mem_addr,
    input  logic [DATA_W-1:0]                  mem_data_in,
    output logic [DATA_W-1:0]                  mem_data,
    output logic [NUM_CLIENTS-1:0]             load_mem,
    output logic [LOC_W-1:0]                   location,
    input  logic [NUM_CLIENTS-1:0]             done_wait,
    output logic [NUM_CLIENTS-1:0]             client_en,
    output logic                               busy,
    output logic                               done,
    output logic                               err
);

    localparam int CI_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int LEN_W = LOC_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + RD_LAT + 1);

    state_t                 state, state_nxt;
    logic [CI_W-1:0]        cur;
    logic [LEN_W-1:0]       cur_len;
    logic [LEN_W-1:0]       issue_cnt;
    logic [TMR_W-1:0]       timer;

    logic [NUM_CLIENTS-1:0] nz;
    logic [MAX_CLIENTS-1:0] nz_ext;
    int                     first_k;
    int                     next_k;
    logic                   first_ok;
    logic                   next_ok;
    logic [CI_W-1:0]        sel_idx;
    logic [ADDR_W-1:0]      sel_base;
    logic [LEN_W-1:0]       sel_len;

    logic                   launch;
    logic                   go_fetch;
    logic                   go_run;
    logic                   go_err;
    logic                   issue;

    logic                   al_valid;
    logic [CI_W-1:0]        al_client;

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_nz
        assign nz[i] = |cfg_len[i*LEN_W +: LEN_W];
    end

    assign nz_ext = MAX_CLIENTS'(nz);

    // The client selected for the next FETCH: first one on a launch, following one from WAIT_DONE.
    always_comb begin
        first_k  = next_nonzero(nz_ext, 0);
        next_k   = next_nonzero(nz_ext, int'(cur) + 1);
        first_ok = (first_k < NUM_CLIENTS);
        next_ok  = (next_k < NUM_CLIENTS);
        sel_idx  = (state == WAIT_DONE) ? CI_W'(next_k) : CI_W'(first_k);
        sel_base = ADDR_W'(cfg_slice(MAX_VEC_W'(cfg_base), int'(sel_idx), ADDR_W));
        sel_len  = LEN_W'(cfg_slice(MAX_VEC_W'(cfg_len), int'(sel_idx), LEN_W));
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        go_fetch  = 1'b0;
        go_run    = 1'b0;
        go_err    = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE, RUN, ERR: begin
                if (start) begin
                    launch = 1'b1;
                    if (first_ok) begin
                        state_nxt = FETCH;
                        go_fetch  = 1'b1;
                    end else begin
                        state_nxt = RUN;
                        go_run    = 1'b1;
                    end
                end
            end
            FETCH: begin
                issue = 1'b1;
                if (issue_cnt == cur_len - LEN_W'(1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (timer == TMR_W'(RD_LAT - 1)) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done_wait[cur]) begin
                    if (next_ok) begin
                        state_nxt = FETCH;
                        go_fetch  = 1'b1;
                    end else begin
                        state_nxt = RUN;
                        go_run    = 1'b1;
                    end
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    state_nxt = ERR;
                    go_err    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur       <= '0;
            cur_len   <= '0;
            issue_cnt <= '0;
            mem_addr  <= '0;
            timer     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            client_en <= '0;
        end else begin
            if (go_fetch) begin
                cur       <= sel_idx;
                cur_len   <= sel_len;
                mem_addr  <= sel_base;
                issue_cnt <= '0;
                busy      <= 1'b1;
            end else if (issue) begin
                mem_addr  <= mem_addr + ADDR_W'(ADDR_STEP);
                issue_cnt <= issue_cnt + LEN_W'(1);
            end

            // One timer serves both the drain countdown and the done_wait timeout.
            if (state != state_nxt) begin
                timer <= '0;
            end else if (state == DRAIN || state == WAIT_DONE) begin
                timer <= timer + TMR_W'(1);
            end

            if (launch) begin
                err  <= 1'b0;
                done <= 1'b0;
            end
            if (go_run) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
            if (go_err) begin
                err  <= 1'b1;
                busy <= 1'b0;
            end

            if (state == RUN && !start) begin
                client_en <= {NUM_CLIENTS{en}};
            end else begin
                client_en <= '0;
            end
        end
    end

    ocm_rd_align #(
        .LAT   (RD_LAT),
        .CI_W  (CI_W),
        .LOC_W (LOC_W)
    ) u_align (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (issue),
        .in_client  (cur),
        .in_loc     (issue_cnt[LOC_W-1:0]),
        .out_valid  (al_valid),
        .out_client (al_client),
        .out_loc    (location)
    );

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_load
        assign load_mem[i] = al_valid && (al_client == CI_W'(i));
    end

    assign mem_data = mem_data_in;

endmodule

`default_nettype wire

// File: tb/tb_ocm_load_sequencer.sv
// ==== tb_ocm_load_sequencer: directed bench, RD_LAT=3 OCM model returning word = address ====
// Rev 1.0
`default_nettype none

module tb_ocm_load_sequencer;

    localparam int ADDR_W = 14;
    localparam int LOC_W  = 8;

    logic                clk;
    logic                rstn;
    logic                start;
    logic                en;
    logic [2*ADDR_W-1:0] cfg_base;
    logic [2*(LOC_W+1)-1:0] cfg_len;
    logic [ADDR_W-1:0]   mem_addr;
    logic [63:0]         mem_data_in;
    logic [63:0]         mem_data;
    logic [1:0]          load_mem;
    logic [LOC_W-1:0]    location;
    logic [1:0]          done_wait;
    logic [1:0]          client_en;
    logic                busy;
    logic                done;
    logic                err;

    int checks;
    int errors;
    int beats   [2];
    int exp_loc [2];
    logic [ADDR_W-1:0] exp_base [2];

    logic [ADDR_W-1:0] p1, p2, p3;

    ocm_load_sequencer #(
        .NUM_CLIENTS (2),
        .ADDR_W      (ADDR_W),
        .DATA_W      (64),
        .LOC_W       (LOC_W),
        .ADDR_STEP   (4),
        .RD_LAT      (3),
        .TIMEOUT     (16)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .en          (en),
        .cfg_base    (cfg_base),
        .cfg_len     (cfg_len),
        .mem_addr    (mem_addr),
        .mem_data_in (mem_data_in),
        .mem_data    (mem_data),
        .load_mem    (load_mem),
        .location    (location),
        .done_wait   (done_wait),
        .client_en   (client_en),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        p1 <= mem_addr;
        p2 <= p1;
        p3 <= p2;
    end
    assign mem_data_in = {50'b0, p3};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and score any load_mem beat against the expected stream.
    task automatic tick();
        int c;
        @(posedge clk);
        #1;
        if (load_mem !== 2'b00) begin
            chk("onehot", 64'($onehot(load_mem)), 64'd1);
            c = load_mem[1] ? 1 : 0;
            chk("location", 64'(location), 64'(exp_loc[c]));
            chk("beat_data", mem_data, {50'b0, exp_base[c] + ADDR_W'(4 * exp_loc[c])});
            beats[c]++;
            exp_loc[c]++;
        end
    endtask

    task automatic set_cfg(input logic [ADDR_W-1:0] b0, input int l0,
                           input logic [ADDR_W-1:0] b1, input int l1);
        cfg_base    = {b1, b0};
        cfg_len     = {9'(l1), 9'(l0)};
        exp_base[0] = b0;
        exp_base[1] = b1;
        for (int i = 0; i < 2; i++) begin
            beats[i]   = 0;
            exp_loc[i] = 0;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_beats(input int c, input int n);
        int k;
        k = 0;
        while (beats[c] < n && k < 2000) begin
            tick();
            k++;
        end
        chk("beats_reached", 64'(beats[c]), 64'(n));
    endtask

    task automatic ack(input int c);
        repeat (3) tick();
        done_wait[c] = 1'b1;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        chk("done_reached", 64'(done), 64'd1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rstn      = 1'b0;
        start     = 1'b0;
        en        = 1'b0;
        done_wait = 2'b00;
        set_cfg(14'h000, 128, 14'h200, 6);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_addr", 64'(mem_addr), 64'h0);
        chk("rst_load_mem", 64'(load_mem), 64'h0);
        chk("rst_location", 64'(location), 64'h0);
        chk("rst_client_en", 64'(client_en), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        rstn = 1'b1;
        repeat (2) tick();

        // Two-client load, then enable.
        pulse_start();
        chk("a_busy", 64'(busy), 64'h1);
        chk("a_addr0", 64'(mem_addr), 64'h000);
        tick();
        chk("a_addr1", 64'(mem_addr), 64'h004);
        wait_beats(0, 128);
        ack(0);
        wait_beats(1, 6);
        ack(1);
        wait_done();
        chk("a_beats0", 64'(beats[0]), 64'd128);
        chk("a_beats1", 64'(beats[1]), 64'd6);
        chk("a_busy_run", 64'(busy), 64'h0);
        chk("a_en_off", 64'(client_en), 64'h0);
        en = 1'b1;
        tick();
        chk("a_en_on", 64'(client_en), 64'h3);

        // Reload from RUN with a stray start while busy.
        done_wait = 2'b00;
        set_cfg(14'h000, 128, 14'h200, 6);
        pulse_start();
        chk("r_en_drop", 64'(client_en), 64'h0);
        chk("r_done_drop", 64'(done), 64'h0);
        chk("r_busy", 64'(busy), 64'h1);
        repeat (10) tick();
        pulse_start();
        chk("r_busy_ign", 64'(busy), 64'h1);
        wait_beats(0, 128);
        ack(0);
        wait_beats(1, 6);
        ack(1);
        wait_done();
        chk("r_beats0", 64'(beats[0]), 64'd128);
        chk("r_beats1", 64'(beats[1]), 64'd6);

        // Zero-length client 0; its done_wait must not matter.
        done_wait = 2'b01;
        set_cfg(14'h000, 0, 14'h100, 4);
        pulse_start();
        chk("z_addr", 64'(mem_addr), 64'h100);
        wait_beats(1, 4);
        ack(1);
        wait_done();
        chk("z_beats0", 64'(beats[0]), 64'd0);
        chk("z_beats1", 64'(beats[1]), 64'd4);
        tick();
        chk("z_en_both", 64'(client_en), 64'h3);

        // Client 1 never acknowledges; its table also wraps the address space.
        done_wait = 2'b00;
        set_cfg(14'h010, 2, 14'h3FFC, 3);
        pulse_start();
        wait_beats(0, 2);
        ack(0);
        wait_beats(1, 3);
        repeat (16) tick();
        chk("t_err_early", 64'(err), 64'h0);
        tick();
        chk("t_err", 64'(err), 64'h1);
        chk("t_busy", 64'(busy), 64'h0);
        chk("t_client_en", 64'(client_en), 64'h0);
        chk("t_done", 64'(done), 64'h0);

        // Restart out of ERR.
        done_wait = 2'b00;
        set_cfg(14'h010, 2, 14'h3FFC, 3);
        pulse_start();
        chk("e_err_clr", 64'(err), 64'h0);
        chk("e_busy", 64'(busy), 64'h1);
        wait_beats(0, 2);
        ack(0);
        wait_beats(1, 3);
        ack(1);
        wait_done();
        chk("e_beats1", 64'(beats[1]), 64'd3);
        chk("e_err_final", 64'(err), 64'h0);

        // Asynchronous reset in the middle of client 0's table.
        done_wait = 2'b00;
        set_cfg(14'h000, 128, 14'h200, 6);
        pulse_start();
        wait_beats(0, 50);
        rstn = 1'b0;
        #1;
        chk("m_load_mem", 64'(load_mem), 64'h0);
        chk("m_mem_addr", 64'(mem_addr), 64'h0);
        chk("m_location", 64'(location), 64'h0);
        chk("m_busy", 64'(busy), 64'h0);
        chk("m_done", 64'(done), 64'h0);
        chk("m_err", 64'(err), 64'h0);
        chk("m_client_en", 64'(client_en), 64'h0);
        #3;
        rstn = 1'b1;
        repeat (12) tick();
        chk("m_no_beats", 64'(beats[0]), 64'd50);
        chk("m_idle_busy", 64'(busy), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ocm_load_sequencer.md
Name: ocm_load_sequencer

Overview:
- Parametrised on-chip-memory coefficient loader. It streams per-client tables from the 64-bit OCM read port into NUM_CLIENTS consumers, for example noise_128_wrapper and ISI_channel_ocm, strictly in client order.
- Each client gets its own load_mem strobe and a shared location index.
- The block waits for each client's done_wait before moving on, then releases all client enables at once.
- It replaces the hand-wired per-block load FSMs in the system top and adds variable table length, configurable read latency, a timeout error and reload.

Parameters:
- NUM_CLIENTS, 2, number of consumers, loaded in index order 0..N-1.
- ADDR_W, 14, OCM port-2 address width.
- DATA_W, 64, OCM read data width.
- LOC_W, 8, location index width; maximum table length is 2^LOC_W words.
- ADDR_STEP, 4, address increment per word.
- RD_LAT, 1, OCM read latency in cycles (1..3).
- TIMEOUT, 1024, cycles allowed for done_wait after a client's last word.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  single-cycle load request
- en  in  1  global run enable, forwarded to clients after loading
- cfg_base  in  NUM_CLIENTS*ADDR_W  per-client start address, client i at slice i
- cfg_len  in  NUM_CLIENTS*(LOC_W+1)  per-client word count, 0..2^LOC_W
- mem_addr  out  ADDR_W  OCM port-2 address
- mem_data_in  in  DATA_W  OCM readdata2
- mem_data  out  DATA_W  read data forwarded to clients (pass-through)
- load_mem  out  NUM_CLIENTS  one-hot; high while the word at location is valid on mem_data
- location  out  LOC_W  word index for the current load_mem beat
- done_wait  in  NUM_CLIENTS  per-client "table accepted" level
- client_en  out  NUM_CLIENTS  per-client enable
- busy  out  1  load sequence in progress
- done  out  1  all clients loaded; block is in RUN
- err  out  1  done_wait timeout occurred (sticky until the next start or reset)

Behaviour:
- Reset values: mem_addr = 0, load_mem = 0, location = 0, client_en = 0, busy = 0, done = 0, err = 0, state = IDLE. Reset clears every internal counter and the RD_LAT delay line.
- cfg_base and cfg_len are sampled per client when that client's FETCH begins. They must be held stable during busy.
- IDLE:
  - start selects k = first client with cfg_len != 0. Drive mem_addr <= base[k], busy <= 1, go to FETCH.
  - If all lengths are 0, go directly to RUN.
- FETCH:
  - One read issued per cycle; issue index j = 0..len-1; mem_addr advances by ADDR_STEP each cycle.
  - Address arithmetic is modulo 2^ADDR_W, with no clamp.
  - After issue len-1, go to DRAIN.
- Beat alignment: issue j produces load_mem[k] = 1 and location = j exactly RD_LAT cycles after mem_addr showed address j. The issue valid and index travel through an RD_LAT-deep register line.
- DRAIN: lasts until the last beat leaves the delay line, then go to WAIT_DONE with the timeout counter cleared.
- WAIT_DONE:
  - done_wait[k] = 1: advance k to the next client with nonzero length and go to FETCH, with mem_addr <= base[k]. If none remains, go to RUN.
  - Timer reaches TIMEOUT: err <= 1, busy <= 0, go to ERR.
  - If done_wait[k] is asserted before WAIT_DONE (early), it is accepted on the first WAIT_DONE cycle.
- RUN:
  - done = 1, busy = 0.
  - client_en[i] <= en for every i, with one cycle of registered latency.
  - Clients with len 0 also receive en.
- ERR: all client_en = 0, err = 1. Only start (clears err and restarts) or reset leaves ERR.
- start handling:
  - start while busy is ignored.
  - start in RUN is a reload: client_en <= 0 and done <= 0 on the same edge, then the sequence restarts from the first client.
- load_mem is never asserted for more than one client in any cycle. location wraps naturally only when len = 2^LOC_W (last index 2^LOC_W - 1).
- Reset mid-FETCH abandons the sequence; no further load_mem beats appear after rstn rises.

Decomposition:
- Shared package ocm_load_pkg holds:
  - state enum: IDLE, FETCH, DRAIN, WAIT_DONE, RUN, ERR;
  - a function extracting the client-i slice of cfg_base/cfg_len;
  - a function computing the next-nonzero-client index.
- One sub-module, ocm_rd_align: an RD_LAT-deep shift line carrying {valid, client index, location}. It has reset and is reused by any future OCM reader.

Test Plan:
- N=2, RD_LAT=1, base0=0x000/len0=128, base1=0x200/len1=6; clients assert done_wait 3 cycles after their last beat:
  - 128 beats on load_mem[0], locations 0..127; mem_addr steps 0x000..0x1FC;
  - then 6 beats on load_mem[1], locations 0..5, addresses 0x200..0x214;
  - done = 1, and client_en = 2'b11 one cycle after en = 1.
- RD_LAT=3 with an OCM model returning word = address: every load_mem beat carries mem_data = base + 4*location. No beat is missing or duplicated.
- len0 = 0, len1 = 4:
  - client 0 gets no load_mem beats, and its done_wait is ignored;
  - client 1 gets 4 beats;
  - RUN enables both clients.
- Client 1 never asserts done_wait, TIMEOUT = 16:
  - err = 1 exactly 16 cycles into WAIT_DONE; busy = 0, client_en = 0;
  - a later start clears err and the sequence reloads cleanly.
- In RUN, pulse start: client_en drops the next cycle, done = 0, and the full sequence repeats with identical beats. A second start during busy has no effect.
- Deassert rstn during beat 50 of client 0: all outputs return to reset values immediately. After release, no load_mem activity occurs until start.
